// File: rtl/least_load_dispatcher.sv
// least_load_dispatcher: sends each accepted job to the enabled, non-full channel with the fewest
// outstanding jobs, through a one-entry registered dispatch stage.
module least_load_dispatcher #(
    parameter int W       = 12,
    parameter int MAX_OUT = 8,
    parameter int TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ch_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_ch,
    output logic [TAG_W-1:0] out_tag,
    input  logic [3:0]       done,
    output logic [3:0]       ch_full,
    output logic             err
);
    localparam logic [W-1:0] MAX = W'(MAX_OUT);

    logic [W-1:0]     cnt_q [4];
    logic [W-1:0]     cnt_d [4];
    logic [3:0]       elig, inc, dec, ch_full_q, ch_full_d;
    logic             out_valid_q, out_valid_d, err_q, err_d, accept, e01, e23;
    logic [1:0]       out_ch_q, out_ch_d, w01, w23, win;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [W-1:0]     c01, c23;

    always_comb begin
        for (int k = 0; k < 4; k++)
            elig[k] = ch_en[k] && (cnt_q[k] < MAX);
        // Two-level min tree; the lower index wins every tie.
        w01 = (elig[1] && (!elig[0] || cnt_q[1] < cnt_q[0])) ? 2'd1 : 2'd0;
        w23 = (elig[3] && (!elig[2] || cnt_q[3] < cnt_q[2])) ? 2'd3 : 2'd2;
        e01 = elig[0] || elig[1];
        e23 = elig[2] || elig[3];
        c01 = cnt_q[w01];
        c23 = cnt_q[w23];
        win = (e23 && (!e01 || c23 < c01)) ? w23 : w01;
        in_ready = !rst && (!out_valid_q || out_ready) && (|elig);
        accept = in_valid && in_ready;
        for (int k = 0; k < 4; k++) begin
            inc[k]       = accept && (win == 2'(k));
            dec[k]       = done[k] && (cnt_q[k] != '0);
            cnt_d[k]     = rst ? '0 : cnt_q[k] + W'(inc[k]) - W'(dec[k]);
            ch_full_d[k] = (cnt_d[k] == MAX);
        end
        err_d       = !rst && (err_q || (|(done & ~dec)));
        out_valid_d = !rst && (accept || (out_valid_q && !out_ready));
        out_ch_d    = rst ? '0 : accept ? win : out_ch_q;
        out_tag_d   = rst ? '0 : accept ? in_tag : out_tag_q;
    end

    always_ff @(posedge clk) begin
        cnt_q       <= cnt_d;
        ch_full_q   <= ch_full_d;
        err_q       <= err_d;
        out_valid_q <= out_valid_d;
        out_ch_q    <= out_ch_d;
        out_tag_q   <= out_tag_d;
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_tag   = out_tag_q;
    assign ch_full   = ch_full_q;
    assign err       = err_q;
endmodule

// File: doc/least_load_dispatcher.md
# least_load_dispatcher

Dispatches tagged jobs to four shared worker channels. Each channel has an outstanding-job counter. Every accepted job goes to the enabled, non-full channel with the fewest outstanding jobs. Workers report completion with `done` pulses, which decrement their channel's counter. Upstream connects through a valid/ready handshake and downstream through a one-entry registered dispatch stage.

## Interface
- `W`, default 12: width of each outstanding counter.
- `MAX_OUT`, default 8: per-channel outstanding limit, 1 ≤ MAX_OUT ≤ 2^W−1.
- `TAG_W`, default 8: width of the job tag.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `ch_en`, in, 4: per-channel enable. A disabled channel receives no new jobs but still accepts `done`.
- `in_valid`, in, 1: upstream job present.
- `in_ready`, out, 1: job accepted when `in_valid && in_ready` at the rising edge.
- `in_tag`, in, TAG_W: job tag.
- `out_valid`, out, 1: dispatch entry valid.
- `out_ready`, in, 1: downstream takes the entry when `out_valid && out_ready`.
- `out_ch`, out, 2: channel assigned to the job.
- `out_tag`, out, TAG_W: tag of the dispatched job.
- `done`, in, 4: one-cycle completion pulse per channel, multiple bits may be set.
- `ch_full`, out, 4: registered, bit k = (cnt[k] == MAX_OUT).
- `err`, out, 1: sticky underflow flag, set when `done[k]` arrives while cnt[k] == 0.

## Operation
Channel selection:
- Eligible set: channel k with `ch_en[k]` high and cnt[k] < MAX_OUT.
- Selection is combinational from the current (pre-edge) counter values.
- The winner is the eligible channel with the minimum count.
- Ties go to the lowest index.
- Comparison is a two-level tree: the winner of pair {0,1} vs the winner of pair {2,3}. The lower pair wins ties at both levels.

Handshake:
- `in_ready = (!out_valid || out_ready) && (eligible set non-empty)`.
- On accept:
  - `out_ch` is loaded with the winner.
  - `out_tag` is loaded with `in_tag`.
  - `out_valid` is set to 1.
  - cnt[winner] increments.
- Downstream take without a new accept clears `out_valid`. `out_ch` and `out_tag` hold their values.
- While `out_valid && !out_ready`, `out_ch` and `out_tag` are held stable.

Counter update, per channel k, each cycle:
- inc = accept && winner==k; dec = done[k] && cnt[k] != 0.
- Next count is cnt + inc − dec.
- inc and dec together leave the count unchanged.
- `done[k]` with cnt[k]==0 leaves the count at 0 and sets `err`.
- Counters never exceed MAX_OUT, because a full channel is never eligible.

Configuration: `ch_en` changes take effect on the next selection. Jobs already counted on a channel remain counted when it is disabled.

Reset effects:
- All cnt = 0.
- `out_valid` = 0, `out_ch` = 0, `out_tag` = 0.
- `ch_full` = 0, `err` = 0.
- `in_ready` is low during reset.
- `done` pulses during reset are ignored.
- A pending dispatch entry is dropped. No counter state survives reset.

## Timing
- Accept at edge N: `out_valid`, `out_ch` and `out_tag` are visible after edge N. cnt and `ch_full` are updated at the same edge.
- Latency from `in_valid` to `out_valid` is 1 cycle.
- Throughput is 1 job per cycle while `out_ready` is held high and an eligible channel exists.
- `done` at edge N: the count drops at edge N. The freed slot is usable for a selection in cycle N+1.
- `in_ready` is combinational from `out_valid`, `out_ready`, cnt and `ch_en`. It does not depend on `in_valid`.
- All eligible channels full or disabled: `in_ready` = 0 until a `done` pulse or an enable change.

## Test plan
- Reset, all enabled, 4 back-to-back jobs (tags 0x10–0x13), `out_ready`=1 → `out_ch` sequence 0,1,2,3; all counts = 1.
- `ch_en`=4'b1010, 3 jobs, no `done` → channels 1,3,1; cnt[1]=2, cnt[3]=1, cnt[0]=cnt[2]=0.
- MAX_OUT=2, all enabled, 8 jobs with no `done` → all `ch_full`=1 and `in_ready`=0. A `done[2]` pulse → `in_ready`=1 the next cycle; the next job goes to channel 2.
- `out_ready`=0 after first accept → `out_valid` held, `out_ch`/`out_tag` stable, `in_ready`=0. Releasing `out_ready` → the next job is accepted in the same cycle.
- cnt[0]=1 with accept to channel 0 and `done[0]` in the same cycle → cnt[0] stays 1. `done[3]` with cnt[3]=0 → `err`=1, cnt[3] stays 0.
- Mid-stream reset with `out_valid`=1 and counts 3,1,2,0 → after the reset edge all counts 0, `out_valid`=0, `err`=0. The first job after reset goes to channel 0.
